// File: rtl/block_drawer_pkg.sv
// Shared types and geometry constants for the block drawer controller and its bench.
package block_drawer_pkg;

    localparam int unsigned TILE         = 20;
    localparam int unsigned BEVEL        = 2;
    localparam int unsigned BLOCK_PIXELS = 408;
    localparam int unsigned GRID_PIXELS  = 404;
    localparam int unsigned STATE_W      = 5;

    typedef enum logic [STATE_W-1:0] {
        IDLE       = 5'd0,
        INIT_TOP   = 5'd1,
        TOP        = 5'd2,
        TOP_B      = 5'd3,
        INIT_BOT   = 5'd4,
        BOT        = 5'd5,
        BOT_B      = 5'd6,
        INIT_LEFT  = 5'd7,
        LEFT       = 5'd8,
        LEFT_B     = 5'd9,
        INIT_RIGHT = 5'd10,
        RIGHT      = 5'd11,
        RIGHT_B    = 5'd12,
        INIT_MAIN  = 5'd13,
        MAIN       = 5'd14,
        DONE       = 5'd15,
        G_INIT     = 5'd16,
        G_TOP      = 5'd17,
        G_BINIT    = 5'd18,
        G_BOT      = 5'd19,
        G_LINIT    = 5'd20,
        G_LEFT     = 5'd21,
        G_RINIT    = 5'd22,
        G_RIGHT    = 5'd23,
        G_MINIT    = 5'd24,
        G_MAIN     = 5'd25
    } drawer_state_t;

endpackage

// File: rtl/block_drawer_ctrl.sv
// Sequencing FSM for the block drawer datapath: one start pulse paints one
// bevelled tile (block mode) or one grid cell (grid mode), one plot per pixel,
// advancing only when the frame buffer accepts (plot && ready).
// Strobes are Mealy outputs: the datapath flags and ready are used in the same
// cycle they are read, so a stalled pixel holds plot with every strobe low.
module block_drawer_ctrl
    import block_drawer_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic grid,
    input  logic ready,
    input  logic x_eq_19md,
    input  logic y_eq_1,
    input  logic y_eq_18,
    input  logic y_eq_19md,
    input  logic x_eq_1,
    input  logic x_eq_18,
    output logic init_top,
    output logic init_bot,
    output logic init_left,
    output logic init_right,
    output logic init_main,
    output logic incr_x,
    output logic decr_x,
    output logic incr_y,
    output logic decr_y,
    output logic zero_x,
    output logic zero_y,
    output logic set_xd,
    output logic set_yd,
    output logic incr_delta,
    output logic reset_x,
    output logic grid_init,
    output logic grid_b_init,
    output logic grid_l_init,
    output logic grid_r_init,
    output logic grid_main_init,
    output logic incr_y_gm,
    output logic plot,
    output logic busy,
    output logic done
);

    drawer_state_t state_q;
    drawer_state_t state_d;

    // State register; reset aborts any draw immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        state_d        = state_q;
        init_top       = 1'b0;
        init_bot       = 1'b0;
        init_left      = 1'b0;
        init_right     = 1'b0;
        init_main      = 1'b0;
        incr_x         = 1'b0;
        decr_x         = 1'b0;
        incr_y         = 1'b0;
        decr_y         = 1'b0;
        zero_x         = 1'b0;
        zero_y         = 1'b0;
        set_xd         = 1'b0;
        set_yd         = 1'b0;
        incr_delta     = 1'b0;
        reset_x        = 1'b0;
        grid_init      = 1'b0;
        grid_b_init    = 1'b0;
        grid_l_init    = 1'b0;
        grid_r_init    = 1'b0;
        grid_main_init = 1'b0;
        incr_y_gm      = 1'b0;
        plot           = 1'b0;
        done           = 1'b0;
        busy           = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = grid ? G_INIT : INIT_TOP;
                end
            end

            // ---------------- block mode: top bevel rows ----------------
            INIT_TOP: begin
                init_top = 1'b1;
                state_d  = TOP;
            end
            TOP: begin
                plot = 1'b1;
                if (ready) begin
                    if (!x_eq_19md) begin
                        incr_x = 1'b1;
                    end else if (!y_eq_1) begin
                        incr_y  = 1'b1;
                        zero_x  = 1'b1;
                        state_d = TOP_B;
                    end else begin
                        state_d = INIT_BOT;
                    end
                end
            end
            TOP_B: begin
                set_xd     = 1'b1;
                incr_delta = 1'b1;
                state_d    = TOP;
            end

            // ---------------- block mode: bottom bevel rows -------------
            INIT_BOT: begin
                init_bot = 1'b1;
                state_d  = BOT;
            end
            BOT: begin
                plot = 1'b1;
                if (ready) begin
                    if (!x_eq_19md) begin
                        incr_x = 1'b1;
                    end else if (!y_eq_18) begin
                        decr_y  = 1'b1;
                        zero_x  = 1'b1;
                        state_d = BOT_B;
                    end else begin
                        state_d = INIT_LEFT;
                    end
                end
            end
            BOT_B: begin
                set_xd     = 1'b1;
                incr_delta = 1'b1;
                state_d    = BOT;
            end

            // ---------------- block mode: left bevel columns ------------
            INIT_LEFT: begin
                init_left = 1'b1;
                state_d   = LEFT;
            end
            LEFT: begin
                plot = 1'b1;
                if (ready) begin
                    if (!y_eq_19md) begin
                        incr_y = 1'b1;
                    end else if (!x_eq_1) begin
                        incr_x  = 1'b1;
                        zero_y  = 1'b1;
                        state_d = LEFT_B;
                    end else begin
                        state_d = INIT_RIGHT;
                    end
                end
            end
            LEFT_B: begin
                set_yd     = 1'b1;
                incr_delta = 1'b1;
                state_d    = LEFT;
            end

            // ---------------- block mode: right bevel columns -----------
            INIT_RIGHT: begin
                init_right = 1'b1;
                state_d    = RIGHT;
            end
            RIGHT: begin
                plot = 1'b1;
                if (ready) begin
                    if (!y_eq_19md) begin
                        incr_y = 1'b1;
                    end else if (!x_eq_18) begin
                        decr_x  = 1'b1;
                        zero_y  = 1'b1;
                        state_d = RIGHT_B;
                    end else begin
                        state_d = INIT_MAIN;
                    end
                end
            end
            RIGHT_B: begin
                set_yd     = 1'b1;
                incr_delta = 1'b1;
                state_d    = RIGHT;
            end

            // ---------------- block mode: interior fill -----------------
            INIT_MAIN: begin
                init_main = 1'b1;
                state_d   = MAIN;
            end
            MAIN: begin
                plot = 1'b1;
                if (ready) begin
                    if (!x_eq_19md) begin
                        incr_x = 1'b1;
                    end else if (!y_eq_19md) begin
                        incr_y  = 1'b1;
                        reset_x = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            // ---------------- grid mode: outline ------------------------
            G_INIT: begin
                grid_init = 1'b1;
                state_d   = G_TOP;
            end
            G_TOP: begin
                plot = 1'b1;
                if (ready) begin
                    if (!x_eq_19md) begin
                        incr_x = 1'b1;
                    end else begin
                        state_d = G_BINIT;
                    end
                end
            end
            G_BINIT: begin
                grid_b_init = 1'b1;
                state_d     = G_BOT;
            end
            G_BOT: begin
                plot = 1'b1;
                if (ready) begin
                    if (!x_eq_19md) begin
                        incr_x = 1'b1;
                    end else begin
                        state_d = G_LINIT;
                    end
                end
            end
            G_LINIT: begin
                grid_l_init = 1'b1;
                state_d     = G_LEFT;
            end
            G_LEFT: begin
                plot = 1'b1;
                if (ready) begin
                    if (!y_eq_19md) begin
                        incr_y = 1'b1;
                    end else begin
                        state_d = G_RINIT;
                    end
                end
            end
            G_RINIT: begin
                grid_r_init = 1'b1;
                state_d     = G_RIGHT;
            end
            G_RIGHT: begin
                plot = 1'b1;
                if (ready) begin
                    if (!y_eq_19md) begin
                        incr_y = 1'b1;
                    end else begin
                        state_d = G_MINIT;
                    end
                end
            end

            // ---------------- grid mode: interior -----------------------
            G_MINIT: begin
                grid_main_init = 1'b1;
                state_d        = G_MAIN;
            end
            G_MAIN: begin
                plot = 1'b1;
                if (ready) begin
                    if (!x_eq_18) begin
                        incr_x = 1'b1;
                    end else if (!y_eq_18) begin
                        incr_y_gm = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
